// File: rtl/mem_bist_ctrl_if.sv
// Native single-port memory bus between the BIST controller (master) and the memory (slave).
interface mem_bist_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST: writes a pattern to every location, reads it back after READ_LAT cycles,
// counts mismatches (saturating) and captures the first failing address/expected/observed.
module mem_bist_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_obs,
  mem_bist_ctrl_if.master   mem
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_pat;
  logic              r_seq;
  logic [WAIT_W-1:0] r_wait;
  logic              r_busy;
  logic              r_done;
  logic [ERR_W-1:0]  r_err_count;
  logic              r_fe_valid;
  logic [ADDR_W-1:0] r_fe_addr;
  logic [DATA_W-1:0] r_fe_exp;
  logic [DATA_W-1:0] r_fe_obs;

  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch;
  logic              w_last_addr;
  logic              w_last_pat;

  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0] pat,
                                                  input logic [ADDR_W-1:0] a);
    logic [DATA_W+ADDR_W-1:0] v_ext;
    logic [DATA_W-1:0]        v;
    v_ext = '0;
    v     = '0;
    case (pat)
      2'd1: begin
        v_ext[ADDR_W-1:0] = a;
        v = v_ext[DATA_W-1:0];
      end
      // Checkerboard: 0xAA-style for even addresses, inverted for odd ones.
      2'd2: for (int unsigned i = 0; i < DATA_W; i++) v[i] = i[0] ^ a[0];
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    w_exp       = f_pattern(r_pat, r_addr);
    w_mismatch  = (mem.mem_data_out != w_exp);
    w_last_addr = (r_addr == '1);
    w_last_pat  = !r_seq || (r_pat == 2'd2);
  end

  always_comb begin
    mem.mem_write   = (r_state == S_WRITE);
    mem.mem_read    = (r_state == S_READ);
    mem.mem_addr    = '0;
    mem.mem_data_in = '0;
    if (r_state == S_WRITE || r_state == S_READ) mem.mem_addr = r_addr;
    if (r_state == S_WRITE) mem.mem_data_in = w_exp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_pat       <= '0;
      r_seq       <= 1'b0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_count <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_addr   <= '0;
      r_fe_exp    <= '0;
      r_fe_obs    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_WRITE;
            r_addr      <= '0;
            r_seq       <= (mode == 2'd3);
            r_pat       <= (mode == 2'd3) ? 2'd0 : mode;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_fe_valid  <= 1'b0;
            r_fe_addr   <= '0;
            r_fe_exp    <= '0;
            r_fe_obs    <= '0;
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 1'b1;
          if (w_last_addr) r_state <= S_READ;
        end
        S_READ: begin
          r_wait  <= '0;
          r_state <= (READ_LAT > 1) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          r_wait <= r_wait + 1'b1;
          if (r_wait == WAIT_LAST) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            if (!r_fe_valid) begin
              r_fe_valid <= 1'b1;
              r_fe_addr  <= r_addr;
              r_fe_exp   <= w_exp;
              r_fe_obs   <= mem.mem_data_out;
            end
          end
          r_addr <= r_addr + 1'b1;
          if (!w_last_addr) begin
            r_state <= S_READ;
          end else if (!w_last_pat) begin
            r_pat   <= r_pat + 2'd1;
            r_state <= S_WRITE;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_done && (r_err_count == '0);
  assign err_count       = r_err_count;
  assign first_err_valid = r_fe_valid;
  assign first_err_addr  = r_fe_addr;
  assign first_err_exp   = r_fe_exp;
  assign first_err_obs   = r_fe_obs;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a READ_LAT=1 instance with a fault-injectable memory and a
// READ_LAT=3 instance whose memory latency can be set to 3 (correct) or 2 (too fast).
module tb_mem_bist_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int EW = 16;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic [1:0] mode_a, mode_b;

  logic busy_a, done_a, pass_a, fv_a;
  logic [EW-1:0] err_a;
  logic [AW-1:0] faddr_a;
  logic [DW-1:0] fexp_a, fobs_a;

  logic busy_b, done_b, pass_b, fv_b;
  logic [EW-1:0] err_b;
  logic [AW-1:0] faddr_b;
  logic [DW-1:0] fexp_b, fobs_b;

  mem_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .ERR_W(EW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_valid(fv_a), .first_err_addr(faddr_a),
    .first_err_exp(fexp_a), .first_err_obs(fobs_a), .mem(bus_a)
  );

  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .ERR_W(EW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_valid(fv_b), .first_err_addr(faddr_b),
    .first_err_exp(fexp_b), .first_err_obs(fobs_b), .mem(bus_b)
  );

  // Memory A: 1-cycle read latency, optional bit3 stuck-at-0 at address 12 on reads.
  logic [DW-1:0] mem_a [DEPTH];
  bit fault_en = 1'b0;
  always @(posedge clk) begin
    if (bus_a.mem_write) mem_a[bus_a.mem_addr] <= bus_a.mem_data_in;
    if (bus_a.mem_read)
      bus_a.mem_data_out <= mem_a[bus_a.mem_addr] &
                            ((fault_en && bus_a.mem_addr == 5'd12) ? 8'hF7 : 8'hFF);
  end

  // Memory B: data valid only transiently at the end of a 2- or 3-stage pipeline.
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] pipe_b [3];
  int model_lat_b = 3;
  always @(posedge clk) begin
    if (bus_b.mem_write) mem_b[bus_b.mem_addr] <= bus_b.mem_data_in;
    pipe_b[0] <= bus_b.mem_read ? mem_b[bus_b.mem_addr] : 8'h00;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_b.mem_data_out = (model_lat_b == 3) ? pipe_b[2] : pipe_b[1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pat(input int pat, input int a);
    case (pat)
      0: return 8'h00;
      1: return 8'(a);
      default: return (a % 2 == 0) ? 8'hAA : 8'h55;
    endcase
  endfunction

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t sb_q[$];

  int busy_cnt_a, wr_cnt_a, rd_cnt_a, busy_cnt_b;

  // Write scoreboard and activity counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (busy_b) busy_cnt_b++;
    if (bus_a.mem_read) rd_cnt_a++;
    if (bus_a.mem_write) begin
      wr_t e;
      wr_cnt_a++;
      chk("strobe_excl", {31'd0, bus_a.mem_read}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", {27'd0, bus_a.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr_data", {19'd0, bus_a.mem_addr, bus_a.mem_data_in}, {19'd0, e.addr, e.data});
      end
    end
  end

  task automatic push_expected(input logic [1:0] m);
    int first, last;
    first = (m == 2'd3) ? 0 : int'(m);
    last  = (m == 2'd3) ? 2 : int'(m);
    for (int p = first; p <= last; p++)
      for (int a = 0; a < DEPTH; a++) sb_q.push_back('{addr: 5'(a), data: exp_pat(p, a)});
  endtask

  typedef struct {
    logic [1:0] mode;
    bit fault;
    int poke;
    int busy, wr, rd, err;
    bit pass, fv;
    int faddr, fexp, fobs;
  } vec_t;

  task automatic run_a(input vec_t v);
    @(negedge clk);
    fault_en = v.fault;
    mode_a = v.mode;
    push_expected(v.mode);
    busy_cnt_a = 0; wr_cnt_a = 0; rd_cnt_a = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    mode_a = ~v.mode;
    chk("accept_state", {28'd0, busy_a, done_a, fv_a, 1'b0} | {16'd0, err_a}, 32'h8);
    for (int i = 1; i < 2000 && !done_a; i++) begin
      start_a = (v.poke != 0 && i == v.poke);
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("done_reached", {31'd0, done_a}, 32'd1);
    chk("busy_cycles", busy_cnt_a, v.busy);
    chk("write_count", wr_cnt_a, v.wr);
    chk("read_count", rd_cnt_a, v.rd);
    chk("err_count", {16'd0, err_a}, v.err);
    chk("pass_busy", {30'd0, pass_a, busy_a}, {30'd0, v.pass, 1'b0});
    chk("first_err", {fv_a, faddr_a, fexp_a, fobs_a},
        {v.fv, 5'(v.faddr), 8'(v.fexp), 8'(v.fobs)});
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic run_b(input logic [1:0] m, input int lat, input int exp_err,
                       input bit exp_pass, input logic [21:0] exp_fe);
    @(negedge clk);
    model_lat_b = lat;
    mode_b = m;
    busy_cnt_b = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 1; i < 2000 && !done_b; i++) @(negedge clk);
    chk("b_done_reached", {31'd0, done_b}, 32'd1);
    chk("b_busy_cycles", busy_cnt_b, 160);
    chk("b_err_count", {16'd0, err_b}, exp_err);
    chk("b_pass", {31'd0, pass_b}, {31'd0, exp_pass});
    chk("b_first_err", {10'd0, fv_b, faddr_b, fexp_b, fobs_b}, {10'd0, exp_fe});
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd0, 1'b0, 0, 96, 32, 32, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00};
    vecs[1] = '{2'd1, 1'b0, 0, 96, 32, 32, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00};
    vecs[2] = '{2'd2, 1'b0, 0, 96, 32, 32, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00};
    vecs[3] = '{2'd1, 1'b1, 0, 96, 32, 32, 1, 1'b0, 1'b1, 12, 8'h0C, 8'h04};
    vecs[4] = '{2'd0, 1'b1, 0, 96, 32, 32, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00};
    vecs[5] = '{2'd2, 1'b1, 0, 96, 32, 32, 1, 1'b0, 1'b1, 12, 8'hAA, 8'hA2};
    vecs[6] = '{2'd3, 1'b1, 0, 288, 96, 96, 2, 1'b0, 1'b1, 12, 8'h0C, 8'h04};
    vecs[7] = '{2'd3, 1'b0, 0, 288, 96, 96, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00};
    vecs[8] = '{2'd1, 1'b0, 10, 96, 32, 32, 0, 1'b1, 1'b0, 0, 8'h00, 8'h00};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_a", {busy_a, done_a, pass_a, fv_a, err_a, faddr_a, fexp_a, fobs_a}, 0);
    chk("reset_a_bus", {bus_a.mem_read, bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data_in}, 0);
    chk("reset_b", {busy_b, done_b, pass_b, fv_b, err_b}, 0);

    foreach (vecs[k]) run_a(vecs[k]);

    // Abort mid-READ: everything must be zero on the cycle after the reset edge.
    @(negedge clk);
    fault_en = 1'b0;
    mode_a = 2'd1;
    push_expected(2'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 200 && !bus_a.mem_read; i++) @(negedge clk);
    chk("saw_read", {31'd0, bus_a.mem_read}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_status", {busy_a, done_a, pass_a, fv_a, err_a, faddr_a, fexp_a, fobs_a}, 0);
    chk("abort_bus", {bus_a.mem_read, bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data_in}, 0);
    rd_cnt_a = 0; wr_cnt_a = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_quiet", rd_cnt_a + wr_cnt_a, 0);
    sb_q.delete();

    run_b(2'd2, 3, 0, 1'b1, 22'd0);
    run_b(2'd1, 3, 0, 1'b1, 22'd0);
    run_b(2'd2, 2, 32, 1'b0, {1'b1, 5'd0, 8'hAA, 8'h00});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Synthesizable memory built-in self-test controller. It drives a single-port read/write memory through its native read/write/addr/data_in/data_out pins and writes a selectable data pattern to every location. It then reads every location back, compares against the expected value, counts mismatches and captures the first failure. It generalises the 32x8 clear/data=address memory test to parametrised width, depth, read latency and pattern modes, and sits beside the memory as a self-checking engine.

Parameters:
ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W locations
DATA_W, 8, memory data width
READ_LAT, 1, cycles from mem_read-asserted edge to valid mem_data_out (>=1)
ERR_W, 16, error counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a test; ignored while busy
mode  input  2  pattern: 0 all-zeros, 1 data=address, 2 checkerboard, 3 run 0,1,2 in sequence
busy  output  1  test in progress
done  output  1  test finished; held until next accepted start or rst
pass  output  1  done && err_count==0
err_count  output  ERR_W  mismatches, saturating
first_err_valid  output  1  at least one mismatch captured
first_err_addr  output  ADDR_W  address of first mismatch
first_err_exp  output  DATA_W  expected data at first mismatch
first_err_obs  output  DATA_W  observed data at first mismatch
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_data_in  output  DATA_W  data to memory
mem_data_out  input  DATA_W  data from memory

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0. Reset mid-test aborts immediately; no further strobes after that edge.
- mem_read and mem_write are never both 1. Both are 0 outside WRITE/READ states.
- Pattern (expected value for address a):
  - mode0: 0
  - mode1: a zero-extended, or truncated to DATA_W
  - mode2: {DATA_W/2{2'b10}} (0xAA for 8 bits) for even a; its inverse (0x55) for odd a; the low bit is used if DATA_W is odd
- mode is sampled only at accepted start; later changes are ignored.
- FSM IDLE -> WRITE -> READ -> WAIT -> CHECK -> (READ | WRITE | DONE):
  - IDLE/DONE: start=1 is accepted. On the next edge: busy=1, done=0, err_count and first_err_* cleared, addr=0, state WRITE.
  - WRITE: one location per cycle, mem_write=1, mem_addr=a, mem_data_in=pattern(a). After DEPTH-1, go to READ with addr=0.
  - READ: one cycle with mem_read=1 and mem_addr=a.
  - WAIT: READ_LAT-1 cycles; skipped when READ_LAT=1.
  - CHECK: mem_data_out sampled at the edge ending this cycle, i.e. READ_LAT edges after the READ edge.
    - On mismatch: err_count+1, saturating at all-ones. If first_err_valid=0, capture addr/exp/obs and set first_err_valid.
    - Then: next addr -> READ; after DEPTH-1, next pattern (mode3 only) -> WRITE addr=0; otherwise DONE.
- Timing: each pattern costs DEPTH*(READ_LAT+2) busy cycles. With defaults that is 96; mode3 is 288.
- DONE: busy=0, done=1, pass = (err_count==0). Outputs are held until rst or a new start.
- Errors accumulate across all sub-patterns of mode3. first_err_* reflects the earliest failure in time.
- start while busy has no effect.

Test Plan:
- Good memory, mode0, defaults: start one cycle -> busy exactly 96 cycles, 32 writes of 0x00, 32 reads; done=1, pass=1, err_count=0, first_err_valid=0.
- Good memory, mode1 -> mem_data_in equals the address on write cycles 0..31; pass=1. Mode2 -> writes alternate 0xAA/0x55 starting with 0xAA at address 0; pass=1.
- Memory model with bit3 stuck-at-0 at address 12, mode1 -> err_count=1, first_err_addr=12, exp=0x0C, obs=0x04, pass=0. Same fault in mode0 -> pass=1.
- Same fault, mode3 -> busy 288 cycles. Errors in mode1 (12≠0x04) and mode2 (exp 0xAA, obs 0xA2) give err_count=2; first_err_exp=0x0C.
- READ_LAT=3 with a 3-cycle-latency model -> busy 160 cycles per pattern; pass=1. A 2-cycle model -> err_count>0.
- rst asserted mid-READ -> next cycle all outputs 0. start during busy is ignored (cycle count unchanged). start in DONE restarts with counters cleared.
